axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 The block SHALL have no parameters; master count is fixed at 2 and widths come from the shared AXI package.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 m_ar_i  input  [1:0] ar_req_t  per-master AR payload {id[3:0], addr[31:0], len[3:0], size[2:0], burst[1:0]}.
REQ-005 m_arvalid_i  input  [1:0]  per-master AR valid.
REQ-006 m_arready_o  output  [1:0]  per-master AR ready.
REQ-007 m_r_o  output  r_rsp_t  R payload {id[3:0], data[31:0], resp[1:0], last}, common to both masters.
REQ-008 m_rvalid_o  output  [1:0]  per-master R valid.
REQ-009 m_rready_i  input  [1:0]  per-master R ready.
REQ-010 s_ar_o  output  ars_req_t  slave-side AR payload, id widened to 8 bits.
REQ-011 s_arvalid_o / s_arready_i  output / input  1  slave-side AR handshake.
REQ-012 s_r_i  input  rs_rsp_t  slave-side R payload, id 8 bits.
REQ-013 s_rvalid_i / s_rready_o  input / output  1  slave-side R handshake.

Function
REQ-014 The FSM SHALL have states IDLE, ADDR, DATA; exactly one read transaction outstanding at any time.
REQ-015 IDLE: if any m_arvalid_i set, winner SHALL be chosen combinationally: a single requester wins; with both set, the master named by priority pointer prio wins.
REQ-016 In IDLE, m_arready_o SHALL be one-hot to the winner in the same cycle (zero if no request); on that handshake the payload and grant index are registered and FSM moves to ADDR.
REQ-017 ADDR: s_arvalid_o=1 with registered payload; s_ar_o.id = {3'b000, grant, master id}; FSM moves to DATA on the cycle s_arvalid_o & s_arready_i.
REQ-018 Master-to-slave AR latency SHALL be exactly 1 cycle (accepted in cycle N, s_arvalid_o high in N+1).
REQ-019 DATA: m_rvalid_o[grant]=s_rvalid_i, other bit 0; s_rready_o=m_rready_i[grant]; m_r_o = s_r_i with id truncated to bits [3:0]; combinational pass-through, no R buffering.
REQ-020 Routing SHALL use the registered grant only; upper bits of s_r_i.id are ignored.
REQ-021 DATA exits to IDLE on s_rvalid_i & s_rready_o & s_r_i.last; on that cycle prio SHALL be set to the non-granted master.
REQ-022 The exit cycle SHALL NOT accept a new AR; earliest next m_arready_o is the following cycle (IDLE).
REQ-023 In IDLE and ADDR, s_rready_o=0, m_rvalid_o=0, m_arready_o only as in REQ-016 (0 in ADDR/DATA).
REQ-024 A master deasserting m_arvalid_i before handshake SHALL simply lose the arbitration round; no state change.
REQ-025 m_r_o SHALL be driven from s_r_i in all states; only valids are gated.

Reset
REQ-026 On rst low: FSM=IDLE, prio=master 0, grant=0, registered payload=0; all valid/ready outputs 0 while rst low.
REQ-027 Reset mid-transaction SHALL abandon it; no R beat forwarded after reset release until a new AR is granted.

Structure
REQ-028 ar_req_t, ars_req_t, r_rsp_t, rs_rsp_t, the FSM state enum and width constants (ID 4, IDS 8, ADDR 32, DATA 32, LEN 4) SHALL live in the shared AXI package.
REQ-029 Winner selection SHALL be a sub-module rr_arbiter2 (inputs req[1:0], prio; output gnt one-hot); the rest is flat.

Verification
REQ-030 M0 only, addr 0x0000_1000 len 3, slave returns 4 beats -> s_arvalid_o one cycle after handshake, s_ar_o.id=0x0?+M0 id, 4 beats only on m_rvalid_o[0], return to IDLE after last.
REQ-031 Both valid after reset -> M0 wins; after completion both valid again -> M1 wins; third round -> M0.
REQ-032 M1 id 0x5, slave holds s_arready_i low 3 cycles -> s_arvalid_o stays high with stable payload, s_ar_o.id=0x15.
REQ-033 DATA with m_rready_i[grant] low for 2 cycles -> s_rready_o low, beat held; m_rvalid_o[other]=0 throughout.
REQ-034 rst asserted in DATA after beat 1 of 4 -> all outputs 0; after release, slave beats with rvalid=1 are not accepted (s_rready_o=0) until new grant.
REQ-035 s_r_i.id upper bits = M0 while grant=M1 -> beat still routed to M1.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared AXI read-channel types and widths for the two-master read arbiter.
// Slave-side IDs are widened so the grant index rides along with the master ID.
package axi_read_arbiter_pkg;

  localparam int ID_W   = 4;
  localparam int IDS_W  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_req_t;

  typedef struct packed {
    logic [IDS_W-1:0]  id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ars_req_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_rsp_t;

  typedef struct packed {
    logic [IDS_W-1:0]  id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } rs_rsp_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} arb_state_t;

  // Slave ID = {000, master index, master ID}
  function automatic ars_req_t widen_ar(input ar_req_t ar, input logic mst);
    ars_req_t r;
    r.id    = {3'b000, mst, ar.id};
    r.addr  = ar.addr;
    r.len   = ar.len;
    r.size  = ar.size;
    r.burst = ar.burst;
    return r;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_rr.sv
// Two-requester priority-pointer arbiter; a lone requester always wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter, one transaction in flight; AR registered once,
// R passed straight through and routed by the registered grant.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  ar_req_t [1:0]     m_ar_i,
  input  logic    [1:0]     m_arvalid_i,
  output logic    [1:0]     m_arready_o,
  output r_rsp_t            m_r_o,
  output logic    [1:0]     m_rvalid_o,
  input  logic    [1:0]     m_rready_i,
  output ars_req_t          s_ar_o,
  output logic              s_arvalid_o,
  input  logic              s_arready_i,
  input  rs_rsp_t           s_r_i,
  input  logic              s_rvalid_i,
  output logic              s_rready_o
);

  arb_state_t state;
  logic       prio;
  logic       grant;
  ars_req_t   ar_q;
  logic [1:0] gnt;
  logic       ar_hs;
  logic       r_last_hs;

  rr_arbiter2 u_arb (.req(m_arvalid_i), .prio(prio), .gnt(gnt));

  // rst gating keeps arready low while reset is held with requests pending
  assign m_arready_o = (rst && state == ST_IDLE) ? gnt : 2'b00;
  assign ar_hs       = |(m_arvalid_i & m_arready_o);

  assign s_arvalid_o = (state == ST_ADDR);
  assign s_ar_o      = ar_q;

  assign s_rready_o  = (state == ST_DATA) && m_rready_i[grant];
  assign r_last_hs   = s_rvalid_i && s_rready_o && s_r_i.last;

  always_comb begin
    m_rvalid_o        = 2'b00;
    m_rvalid_o[grant] = (state == ST_DATA) && s_rvalid_i;
  end

  assign m_r_o = '{id:   s_r_i.id[ID_W-1:0],
                   data: s_r_i.data,
                   resp: s_r_i.resp,
                   last: s_r_i.last};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      prio  <= 1'b0;
      grant <= 1'b0;
      ar_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (ar_hs) begin
          ar_q  <= widen_ar(m_ar_i[gnt[1]], gnt[1]);
          grant <= gnt[1];
          state <= ST_ADDR;
        end
        ST_ADDR: if (s_arready_i) state <= ST_DATA;
        ST_DATA: if (r_last_hs) begin
          prio  <= ~grant;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench: vector table of AR/R transactions with AR and R scoreboards,
// plus hand sequences for early AR withdrawal and reset mid-burst.
module tb_axi_read_arbiter;
  import axi_read_arbiter_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  ar_req_t [1:0] m_ar_i;
  logic    [1:0] m_arvalid_i;
  logic    [1:0] m_arready_o;
  r_rsp_t        m_r_o;
  logic    [1:0] m_rvalid_o;
  logic    [1:0] m_rready_i;
  ars_req_t      s_ar_o;
  logic          s_arvalid_o;
  logic          s_arready_i;
  rs_rsp_t       s_r_i;
  logic          s_rvalid_i;
  logic          s_rready_o;

  int checks = 0;
  int failures = 0;

  ars_req_t ar_sb[$];
  r_rsp_t   r_sb[$];

  typedef struct {
    logic [1:0]  req;
    logic [3:0]  id0;
    logic [3:0]  id1;
    logic [31:0] addr;
    logic [3:0]  len;
    int          ar_stall;
    int          r_stall;
    logic [3:0]  rid_hi;
    int          win;
  } vec_t;

  vec_t vt[8];

  always #5 clk = ~clk;

  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .m_ar_i(m_ar_i), .m_arvalid_i(m_arvalid_i), .m_arready_o(m_arready_o),
    .m_r_o(m_r_o), .m_rvalid_o(m_rvalid_o), .m_rready_i(m_rready_i),
    .s_ar_o(s_ar_o), .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready_i),
    .s_r_i(s_r_i), .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_arready"}, 64'(m_arready_o), 64'(0));
    chk({nm, "_s_arvalid"}, 64'(s_arvalid_o), 64'(0));
    chk({nm, "_s_rready"}, 64'(s_rready_o), 64'(0));
    chk({nm, "_rvalid"}, 64'(m_rvalid_o), 64'(0));
  endtask

  task automatic run_vec(input vec_t v);
    ar_req_t     a0, a1, aw;
    ars_req_t    exp_ar;
    r_rsp_t      exp_r;
    logic [1:0]  wmask;
    logic [31:0] d;
    wmask = 2'b01 << v.win;
    a0 = '{id: v.id0, addr: v.addr, len: v.len, size: 3'd2, burst: 2'd1};
    a1 = '{id: v.id1, addr: v.addr + 32'h100, len: v.len, size: 3'd2, burst: 2'd1};
    aw = (v.win == 1) ? a1 : a0;
    @(negedge clk);
    m_ar_i[0] = a0; m_ar_i[1] = a1; m_arvalid_i = v.req; #1;
    chk("arready_win", 64'(m_arready_o), 64'(wmask));
    chk("s_arvalid_idle", 64'(s_arvalid_o), 64'(0));
    ar_sb.push_back('{id: {3'b000, 1'(v.win), aw.id}, addr: aw.addr, len: aw.len,
                      size: aw.size, burst: aw.burst});
    @(negedge clk);
    m_arvalid_i = 2'b11;  // pending requests must not be accepted while busy
    for (int i = 0; i <= v.ar_stall; i++) begin
      if (i > 0) @(negedge clk);
      s_arready_i = (i == v.ar_stall); #1;
      chk("s_arvalid", 64'(s_arvalid_o), 64'(1));
      chk("arready_addr", 64'(m_arready_o), 64'(0));
      if (ar_sb.size() == 0) begin
        checks++; failures++; $display("FAIL ar_sb_empty");
      end else if (s_arready_i) begin
        exp_ar = ar_sb.pop_front();
        chk("s_ar", 64'(s_ar_o), 64'(exp_ar));
      end else chk("s_ar_hold", 64'(s_ar_o), 64'(ar_sb[0]));
    end
    @(negedge clk);
    s_arready_i = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      if (b > 0) @(negedge clk);
      d = $urandom;
      s_r_i = '{id: {v.rid_hi, aw.id}, data: d, resp: 2'(b), last: (b == int'(v.len))};
      s_rvalid_i = 1'b1;
      r_sb.push_back('{id: aw.id, data: d, resp: 2'(b), last: (b == int'(v.len))});
      if (b == 1) for (int s = 0; s < v.r_stall; s++) begin
        m_rready_i = ~wmask; #1;
        chk("s_rready_stall", 64'(s_rready_o), 64'(0));
        chk("rvalid_stall", 64'(m_rvalid_o), 64'(wmask));
        @(negedge clk);
      end
      m_rready_i = wmask; #1;
      chk("rvalid", 64'(m_rvalid_o), 64'(wmask));
      chk("s_rready", 64'(s_rready_o), 64'(1));
      chk("arready_data", 64'(m_arready_o), 64'(0));
      exp_r = r_sb.pop_front();
      chk("r_beat", 64'(m_r_o), 64'(exp_r));
    end
    @(negedge clk);
    s_rvalid_i = 1'b0; m_arvalid_i = 2'b00; m_rready_i = 2'b00; #1;
    chk("rvalid_idle", 64'(m_rvalid_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'b11, 4'h3, 4'h9, 32'h0000_1000, 4'd3, 0, 0, 4'h0, 0};
    vt[1] = '{2'b11, 4'h2, 4'h7, 32'h0000_2000, 4'd1, 0, 0, 4'h1, 1};
    vt[2] = '{2'b11, 4'h4, 4'h6, 32'h0000_3000, 4'd2, 0, 0, 4'h0, 0};
    vt[3] = '{2'b01, 4'h1, 4'h8, 32'h0000_4000, 4'd0, 0, 0, 4'h0, 0};
    vt[4] = '{2'b10, 4'h0, 4'h5, 32'h0000_5000, 4'd1, 3, 0, 4'h1, 1};
    vt[5] = '{2'b10, 4'h0, 4'h5, 32'h0000_6000, 4'd3, 0, 2, 4'h0, 1};
    vt[6] = '{2'b11, 4'hA, 4'hB, 32'h0000_7000, 4'd0, 0, 0, 4'h0, 0};
    vt[7] = '{2'b11, 4'hC, 4'hD, 32'h0000_8000, 4'd1, 0, 0, 4'h0, 0};

    rst = 1'b0; m_ar_i = '0; m_arvalid_i = 2'b11; m_rready_i = 2'b11;
    s_arready_i = 1'b0; s_r_i = '0; s_rvalid_i = 1'b1;
    #6;
    chk_quiet("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1; m_arvalid_i = 2'b00; #1;
    chk_quiet("post_reset");
    s_rvalid_i = 1'b0; m_rready_i = 2'b00;

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // withdrawn request loses the round without any state change
    @(negedge clk);
    m_arvalid_i = 2'b01; #1;
    chk("withdraw_arready", 64'(m_arready_o), 64'(2'b01));
    #2 m_arvalid_i = 2'b00;
    @(negedge clk); #1;
    chk("withdraw_s_arvalid", 64'(s_arvalid_o), 64'(0));
    chk("withdraw_idle_arready", 64'(m_arready_o), 64'(0));

    // reset during a burst granted to M1
    @(negedge clk);
    m_ar_i[1] = '{id: 4'h5, addr: 32'h0000_9000, len: 4'd3, size: 3'd2, burst: 2'd1};
    m_arvalid_i = 2'b10; #1;
    chk("rst_seq_arready", 64'(m_arready_o), 64'(2'b10));
    @(negedge clk);
    m_arvalid_i = 2'b00; s_arready_i = 1'b1; #1;
    chk("rst_seq_s_arvalid", 64'(s_arvalid_o), 64'(1));
    @(negedge clk);
    s_arready_i = 1'b0; m_rready_i = 2'b10; s_rvalid_i = 1'b1;
    s_r_i = '{id: 8'h15, data: 32'hCAFE_0000, resp: 2'd0, last: 1'b0}; #1;
    chk("rst_seq_beat0", 64'(m_rvalid_o), 64'(2'b10));
    @(negedge clk);
    s_r_i.data = 32'hCAFE_0001; rst = 1'b0; m_arvalid_i = 2'b11; m_rready_i = 2'b11; #1;
    chk_quiet("rst_mid");
    @(negedge clk);
    rst = 1'b1; m_arvalid_i = 2'b00; #1;
    chk("rst_rel_s_rready", 64'(s_rready_o), 64'(0));
    chk("rst_rel_rvalid", 64'(m_rvalid_o), 64'(0));
    @(negedge clk); #1;
    chk("rst_rel2_s_rready", 64'(s_rready_o), 64'(0));
    chk("rst_rel2_rvalid", 64'(m_rvalid_o), 64'(0));
    s_rvalid_i = 1'b0; m_rready_i = 2'b00;

    // prio back at M0 after reset
    run_vec(vt[7]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
